// File: rtl/rvfi_retire_buffer_if.sv
// Commit-side record bus and trace-side valid/ready stream of the RVFI retire buffer.
// The slave modport is the buffer itself; the master modport is the commit stage plus trace sink.
interface rvfi_retire_buffer_if #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned IDW   = (NRET > 1) ? $clog2(NRET) : 1,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
);
    logic [NRET-1:0]      commit_valid_i;
    logic [NRET*ILEN-1:0] commit_insn_i;
    logic [NRET*XLEN-1:0] commit_pc_i;
    logic [NRET-1:0]      commit_trap_i;
    logic [NRET*5-1:0]    commit_rd_addr_i;
    logic [NRET*XLEN-1:0] commit_rd_wdata_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [63:0]          out_order_o;
    logic [63:0]          out_cycle_o;
    logic [IDW-1:0]       out_nret_id_o;
    logic [ILEN-1:0]      out_insn_o;
    logic [XLEN-1:0]      out_pc_o;
    logic                 out_trap_o;
    logic [4:0]           out_rd_addr_o;
    logic [XLEN-1:0]      out_rd_wdata_o;

    logic [CW-1:0]        count_o;
    logic                 overflow_o;
    logic [31:0]          drop_cnt_o;

    modport slave (
        input  commit_valid_i, commit_insn_i, commit_pc_i, commit_trap_i,
               commit_rd_addr_i, commit_rd_wdata_i, out_ready_i,
        output out_valid_o, out_order_o, out_cycle_o, out_nret_id_o, out_insn_o,
               out_pc_o, out_trap_o, out_rd_addr_o, out_rd_wdata_o,
               count_o, overflow_o, drop_cnt_o
    );

    modport master (
        output commit_valid_i, commit_insn_i, commit_pc_i, commit_trap_i,
               commit_rd_addr_i, commit_rd_wdata_i, out_ready_i,
        input  out_valid_o, out_order_o, out_cycle_o, out_nret_id_o, out_insn_o,
               out_pc_o, out_trap_o, out_rd_addr_o, out_rd_wdata_o,
               count_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// Multi-port RVFI retirement buffer: stamps order/cycle/port on each retired record,
// compacts valid commit ports in program order and streams them out one per cycle.
module rvfi_retire_buffer #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned IDW   = (NRET > 1) ? $clog2(NRET) : 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    rvfi_retire_buffer_if.slave  bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned NW = $clog2(NRET + 1);

    typedef struct packed {
        logic [63:0]     order;
        logic [63:0]     cycle;
        logic [IDW-1:0]  nret_id;
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } rec_t;

    rec_t            mem_q [DEPTH];
    rec_t            mem_d [DEPTH];
    rec_t            out_rec_q, out_rec_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [63:0]     order_q, order_d;
    logic [63:0]     cycle_q, cycle_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     drop_cnt_q, drop_cnt_d;

    rec_t            in_rec_c [NRET];
    logic [NW-1:0]   slot_c   [NRET];
    logic [NW-1:0]   n_c;
    logic            pop_c;
    logic            accept_c;
    logic [32:0]     drop_sum_c;

    // Compaction: each valid port lands at the slot equal to the number of valid ports below it.
    always_comb begin
        n_c = '0;
        for (int k = 0; k < NRET; k++) begin
            slot_c[k]            = n_c;
            in_rec_c[k].order    = order_q + 64'(n_c);
            in_rec_c[k].cycle    = cycle_q;
            in_rec_c[k].nret_id  = IDW'(k);
            in_rec_c[k].insn     = bus.commit_insn_i[k*ILEN +: ILEN];
            in_rec_c[k].pc       = bus.commit_pc_i[k*XLEN +: XLEN];
            in_rec_c[k].trap     = bus.commit_trap_i[k];
            in_rec_c[k].rd_addr  = bus.commit_rd_addr_i[k*5 +: 5];
            in_rec_c[k].rd_wdata = bus.commit_rd_wdata_i[k*XLEN +: XLEN];
            if (bus.commit_valid_i[k]) begin
                n_c = n_c + NW'(1);
            end
        end
    end

    // Whole-group admission against the space left after this cycle's pop.
    always_comb begin
        pop_c    = out_valid_q & bus.out_ready_i;
        accept_c = (32'(count_q) - 32'(pop_c) + 32'(n_c)) <= DEPTH;
    end

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q + PW'(pop_c);
        wr_ptr_d    = wr_ptr_q;
        count_d     = CW'(32'(count_q) - 32'(pop_c));
        order_d     = order_q + 64'(n_c);
        cycle_d     = cycle_q + 64'd1;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        drop_sum_c  = {1'b0, drop_cnt_q} + 33'(n_c);

        if (accept_c) begin
            for (int k = 0; k < NRET; k++) begin
                if (bus.commit_valid_i[k]) begin
                    mem_d[wr_ptr_q + PW'(slot_c[k])] = in_rec_c[k];
                end
            end
            wr_ptr_d = wr_ptr_q + PW'(n_c);
            count_d  = count_d + CW'(n_c);
        end else begin
            overflow_d = 1'b1;
            drop_cnt_d = drop_sum_c[32] ? '1 : drop_sum_c[31:0];
        end

        // Head register preloads the entry that will be at the read pointer next cycle.
        out_valid_d = (count_d != '0);
        out_rec_d   = out_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_rec_q   <= '0;
            order_q     <= '0;
            cycle_q     <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_rec_q   <= out_rec_d;
            order_q     <= order_d;
            cycle_q     <= cycle_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is only ever read through occupied slots, so it needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_order_o    = out_rec_q.order;
    assign bus.out_cycle_o    = out_rec_q.cycle;
    assign bus.out_nret_id_o  = out_rec_q.nret_id;
    assign bus.out_insn_o     = out_rec_q.insn;
    assign bus.out_pc_o       = out_rec_q.pc;
    assign bus.out_trap_o     = out_rec_q.trap;
    assign bus.out_rd_addr_o  = out_rec_q.rd_addr;
    assign bus.out_rd_wdata_o = out_rec_q.rd_wdata;
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.drop_cnt_o     = drop_cnt_q;
endmodule

// File: doc/rvfi_retire_buffer.md
Name: rvfi_retire_buffer

Overview:
Parametrised retirement trace buffer for the RVFI trace path. Accepts up to NRET retired-instruction records per cycle from the commit stage. Stamps each record with a global retirement order, the commit cycle count and its commit-port index, then serialises the records in program order through a FIFO. Output is a valid/ready stream consumed by the trace sink or testbench monitor, one record per cycle. It replaces the flat per-cycle record with a buffered, multi-port, back-pressurable stream.

Parameters:
NRET, 2, number of commit ports; port 0 is oldest within a cycle
DEPTH, 8, FIFO entries; power of two, DEPTH >= NRET
XLEN, 64, PC and register data width
ILEN, 32, instruction word width
IDW, $clog2(NRET) or 1 if NRET==1, port-index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
commit_valid_i  in  NRET  per-port retire valid
commit_insn_i  in  NRET*ILEN  instruction words, port k at bits [k*ILEN +: ILEN]
commit_pc_i  in  NRET*XLEN  PC of retired instruction
commit_trap_i  in  NRET  instruction trapped
commit_rd_addr_i  in  NRET*5  destination register, 0 = none
commit_rd_wdata_i  in  NRET*XLEN  destination write data
out_valid_o  out  1  head record valid
out_ready_i  in  1  sink accepts head
out_order_o  out  64  retirement order of head
out_cycle_o  out  64  cycle count at commit of head
out_nret_id_o  out  IDW  commit port index of head
out_insn_o  out  ILEN  head instruction
out_pc_o  out  XLEN  head PC
out_trap_o  out  1  head trap
out_rd_addr_o  out  5  head rd
out_rd_wdata_o  out  XLEN  head rd data
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a commit group was dropped
drop_cnt_o  out  32  number of records dropped, saturating

Behaviour:
- Reset (synchronous, rst_i high at clock edge): FIFO empty, pointers 0, count_o=0, out_valid_o=0, all out_* data=0, order counter=0, cycle counter=0, overflow_o=0, drop_cnt_o=0. Reset mid-operation discards all buffered records; no output is produced in the cycle following reset.
- Cycle counter: 64-bit, increments by 1 every non-reset cycle and wraps modulo 2^64. Each record is stamped with the counter value in its commit cycle.
- Push: N = popcount(commit_valid_i). Valid ports are compacted in ascending port index, so lower index is written first and is older. Holes are allowed, e.g. valid=2'b10 pushes only port 1, with nret_id=1.
- Order: each pushed record k (0..N-1 after compaction) gets order_cnt+k; order_cnt then advances by N. Order values start at 0.
- Pop: occurs when out_valid_o && out_ready_i. It frees one entry in the same cycle.
- Capacity check: accept the whole group iff count - pop + N <= DEPTH. Otherwise drop the entire group with no partial writes.
- On a drop: overflow_o is set and stays set until reset; drop_cnt_o increases by N and saturates at 2^32-1; order_cnt still advances by N, so gaps in out_order_o expose the loss. Commit ports are never back-pressured.
- Latency: a record pushed in cycle t is visible at the output no earlier than t+1. There is no input-to-output combinational path. out_valid_o = (count != 0), registered.
- Head stability: while out_valid_o && !out_ready_i, all out_* outputs hold constant.
- Pointers wrap modulo DEPTH. Simultaneous push and pop is legal at any occupancy, including full (a pop frees the space the push uses) and empty (a push into an empty FIFO appears next cycle).
- count_o is updated as count - pop + accepted N.

Test Plan:
- Reset, then push port 0 only (valid=01, pc=0x80000000), ready=1 -> next cycle out_valid=1, order=0, nret_id=0, out_cycle equals the commit-cycle stamp, count_o returns to 0 after the pop.
- Two-wide commit for 4 cycles with ready=1 (NRET=2) -> 8 records, orders 0..7 in sequence, nret_id alternating 0,1, pairs sharing one cycle stamp.
- ready=0, push 4 pairs (count=8, full), then a 5th pair -> group dropped, overflow_o=1, drop_cnt_o=2; after draining, orders are 0..7; the next push has order 10.
- Full FIFO, ready=1 and valid=01 in the same cycle -> push accepted, count stays 8, no drop.
- Hole pattern valid=10 with rd_addr=5, rd_wdata=0xDEAD -> single record, nret_id=1, rd fields match.
- rst_i asserted with 5 entries buffered -> next cycle count_o=0, out_valid_o=0, overflow_o=0; the next push gets order 0.
